vscpu_mem_handshake_core: RTL and testbench

//  Parametrised successor of the single-memory VerySimpleCPU core. Executes the full 16-opcode VSCPU ISA

---
 rtl/vscpu_pkg.sv | 43 ++++
 rtl/vscpu_alu.sv | 38 +++
 rtl/vscpu_mem_handshake_core.sv | 173 +++++++++++++++++
 tb/tb_vscpu_mem_handshake_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// rtl/vscpu_pkg.sv - shared opcode, state and sequencing definitions for the VSCPU core
// Purpose: opcode numbers of the 16-entry VSCPU ISA (3-bit op + imm flag), FSM state
//          encoding, and helpers that decide which operand reads an opcode needs.
// Ports:   none (package).
package vscpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  // Position of the immediate flag inside the top opcode nibble (op sits above it).
  localparam int IMM_BIT = 0;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_RDA   = 3'd1;
  localparam logic [2:0] S_RDB   = 3'd2;
  localparam logic [2:0] S_RDIND = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  // mem[A] is read by every ALU op, BZJ/BZJi and CPIi (as the write pointer).
  function automatic logic need_rda(input logic [2:0] op, input logic imm);
    case (op)
      OP_CP:   return 1'b0;
      OP_CPI:  return imm;
      default: return 1'b1;
    endcase
  endfunction

  // mem[B] is read whenever B is an address rather than an immediate; CPIi uses it as data.
  function automatic logic need_rdb(input logic [2:0] op, input logic imm);
    case (op)
      OP_CPI:  return 1'b1;
      default: return !imm;
    endcase
  endfunction

endpackage

// File: rtl/vscpu_alu.sv
// rtl/vscpu_alu.sv - combinational VSCPU arithmetic unit
// Purpose: computes ADD/NAND/SRL/LT/MUL on r1 and the second operand x, modulo 2^DATA_W.
// Ports:   op_i (3-bit opcode), r1_i (first operand), x_i (second operand), result_o.
module vscpu_alu
  import vscpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] r1_i,
  input  logic [DATA_W-1:0] x_i,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [DATA_W-1:0] DW  = DATA_W'(DATA_W);
  localparam logic [DATA_W:0]   DW2 = (DATA_W + 1)'(2 * DATA_W);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = r1_i + x_i;
      OP_NAND: result_o = ~(r1_i & x_i);
      OP_LT:   result_o = {{(DATA_W-1){1'b0}}, (r1_i < x_i)};
      OP_MUL:  result_o = r1_i * x_i;
      OP_SRL: begin
        // Amounts in [DATA_W, 2*DATA_W) turn into a left shift; anything larger is 0.
        if (x_i < DW)
          result_o = r1_i >> x_i;
        else if ({1'b0, x_i} < DW2)
          result_o = r1_i << (x_i - DW);
        else
          result_o = '0;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/vscpu_mem_handshake_core.sv
// rtl/vscpu_mem_handshake_core.sv - VSCPU core on a single req/ack memory port
// Purpose: runs the VSCPU ISA against one shared memory with wait states, halts at
//          instruction boundaries, pulses retire on completion and exposes the PC.
// Ports:   clk, rst (async, active-high); mem_req/mem_we/mem_addr/mem_wdata out,
//          mem_rdata/mem_ack in; halt_req in, halted/retire/pc out.
module vscpu_mem_handshake_core
  import vscpu_pkg::*;
#(
  parameter int                ADDR_W = 14,
  parameter int                DATA_W = 32,
  parameter logic [ADDR_W-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              halt_req,
  output logic              halted,
  output logic              retire,
  output logic [ADDR_W-1:0] pc
);

  if (DATA_W < 2 * ADDR_W + 4) begin : g_width_check
    $error("vscpu_mem_handshake_core: DATA_W must be >= 2*ADDR_W+4");
  end

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] iw_q, iw_d, r1_q, r1_d, r2_q, r2_d;
  logic              req_q, req_d, we_q, we_d, retire_q, retire_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // On the fetch ack the word is still on mem_rdata, so decode it directly; the
  // next access can then be issued back-to-back on the same edge.
  logic [DATA_W-1:0] cur_iw, b_ext, bzji_sum, alu_x, alu_res;
  logic [2:0]        op;
  logic              imm, done;
  logic [ADDR_W-1:0] fld_a, fld_b, pc_inc;

  assign cur_iw   = (state_q == S_FETCH) ? mem_rdata : iw_q;
  assign op       = cur_iw[2*ADDR_W+3 -: 3];
  assign imm      = cur_iw[2*ADDR_W+IMM_BIT];
  assign fld_a    = cur_iw[2*ADDR_W-1:ADDR_W];
  assign fld_b    = cur_iw[ADDR_W-1:0];
  assign b_ext    = {{(DATA_W-ADDR_W){1'b0}}, fld_b};
  assign bzji_sum = mem_rdata + b_ext;
  assign pc_inc   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iw_d     = iw_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    retire_d = 1'b0;
    done     = 1'b0;
    if (state_q == S_HALT) begin
      if (!halt_req) state_d = S_FETCH;
    end else if (req_q && mem_ack) begin
      case (state_q)
        S_FETCH: begin
          iw_d = mem_rdata;
          if (need_rda(op, imm))      state_d = S_RDA;
          else if (need_rdb(op, imm)) state_d = S_RDB;
          else                        state_d = S_WRITE;
        end
        S_RDA: begin
          r1_d = mem_rdata;
          if (need_rdb(op, imm)) state_d = S_RDB;
          else if (op == OP_BZJ) begin
            done = 1'b1;
            pc_d = bzji_sum[ADDR_W-1:0];
          end else state_d = S_WRITE;
        end
        S_RDB: begin
          r2_d = mem_rdata;
          if (op == OP_CPI && !imm) state_d = S_RDIND;
          else if (op == OP_BZJ) begin
            done = 1'b1;
            pc_d = (mem_rdata == '0) ? r1_q[ADDR_W-1:0] : pc_inc;
          end else state_d = S_WRITE;
        end
        S_RDIND: begin
          r2_d    = mem_rdata;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          done = 1'b1;
          pc_d = pc_inc;
        end
        default: state_d = S_FETCH;
      endcase
      if (done) begin
        retire_d = 1'b1;
        state_d  = halt_req ? S_HALT : S_FETCH;
      end
    end
  end

  assign alu_x = imm ? b_ext : r2_d;

  vscpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op),
    .r1_i     (r1_d),
    .x_i      (alu_x),
    .result_o (alu_res)
  );

  // Access outputs are registered from the next-state values, so they only change
  // on an ack edge (or when entering/leaving HALT) and stay stable through waits.
  always_comb begin
    req_d   = (state_d != S_HALT);
    we_d    = 1'b0;
    addr_d  = pc_d;
    wdata_d = '0;
    case (state_d)
      S_RDA:   addr_d = fld_a;
      S_RDB:   addr_d = fld_b;
      S_RDIND: addr_d = r2_d[ADDR_W-1:0];
      S_WRITE: begin
        we_d   = 1'b1;
        addr_d = (op == OP_CPI && imm) ? r1_d[ADDR_W-1:0] : fld_a;
        case (op)
          OP_CP:   wdata_d = imm ? b_ext : r2_d;
          OP_CPI:  wdata_d = r2_d;
          default: wdata_d = alu_res;
        endcase
      end
      S_HALT:  addr_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RST;
      iw_q     <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      iw_q     <= iw_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = (state_q == S_HALT);
  assign retire    = retire_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_vscpu_mem_handshake_core.sv
// tb/tb_vscpu_mem_handshake_core.sv - self-checking bench for vscpu_mem_handshake_core
module tb_vscpu_mem_handshake_core;
  import vscpu_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, halted, retire;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          halt_req = 1'b1;

  always #5 clk = ~clk;

  vscpu_mem_handshake_core #(.ADDR_W(AW), .DATA_W(DW), .PC_RST(14'd0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt_req(halt_req), .halted(halted), .retire(retire), .pc(pc)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t e_pop;

  typedef struct {
    logic [2:0] op; logic imm; logic [AW-1:0] a; logic [AW-1:0] b;
    logic [DW-1:0] ma; logic [DW-1:0] mb; logic [AW-1:0] xa; logic [DW-1:0] xv;
    int waits; bit wr; logic [AW-1:0] waddr; logic [DW-1:0] wdata;
    logic [AW-1:0] epc; int nacc;
  } vec_t;
  vec_t vt [19];

  int wait_n = 0, wcnt = 0, n_acc = 0, n_ret = 0;
  bit in_acc = 0, ack_given = 0;
  logic [AW-1:0] cur_addr;
  logic          cur_we;
  logic [DW-1:0] cur_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_iw(input logic [2:0] op, input logic imm,
                                          input logic [AW-1:0] a, input logic [AW-1:0] b);
    return {op, imm, a, b};
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic imm, input logic [AW-1:0] a,
      input logic [AW-1:0] b, input logic [DW-1:0] ma, input logic [DW-1:0] mb,
      input logic [AW-1:0] xa, input logic [DW-1:0] xv, input int waits, input bit wr,
      input logic [AW-1:0] waddr, input logic [DW-1:0] wdata, input logic [AW-1:0] epc,
      input int nacc);
    vec_t v;
    v.op = op; v.imm = imm; v.a = a; v.b = b; v.ma = ma; v.mb = mb; v.xa = xa; v.xv = xv;
    v.waits = waits; v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.epc = epc; v.nacc = nacc;
    return v;
  endfunction

  // Memory responder: ack after wait_n wait cycles, write on completion, scoreboard writes.
  always @(negedge clk) begin
    if (rst) begin
      in_acc = 0; ack_given = 0; mem_ack = 1'b0;
    end else begin
      if (retire) n_ret++;
      if (ack_given) begin
        n_acc++;
        if (cur_we) begin
          mem[cur_addr] = cur_wdata;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", cur_addr, cur_wdata);
          end else begin
            e_pop = exp_q.pop_front();
            chk("wr_addr", 64'(cur_addr), 64'(e_pop.addr));
            chk("wr_data", 64'(cur_wdata), 64'(e_pop.data));
          end
        end
        in_acc = 0; ack_given = 0;
      end
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!in_acc) begin
          in_acc = 1; cur_addr = mem_addr; cur_we = mem_we; cur_wdata = mem_wdata; wcnt = wait_n;
        end else begin
          chk("hold_addr", 64'(mem_addr), 64'(cur_addr));
          chk("hold_we", 64'(mem_we), 64'(cur_we));
          chk("hold_wdata", 64'(mem_wdata), 64'(cur_wdata));
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1; mem_rdata = mem[mem_addr]; ack_given = 1;
        end else wcnt--;
      end else if (in_acc) begin
        checks++; errors++;
        $display("FAIL req_dropped: mem_req 0 during access to 0x%0h, expected 1", cur_addr);
        in_acc = 0;
      end
    end
  end

  task automatic start_clean();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic release_rst();
    @(negedge clk);
    n_acc = 0; n_ret = 0; rst = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int bound);
    int k = 0;
    while (!halted && k < bound) begin @(negedge clk); k++; end
    if (!halted) begin
      checks++; errors++;
      $display("FAIL %s_timeout: halted=0 after %0d cycles, expected 1", name, bound);
    end
    @(negedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wr_t e;
    start_clean();
    halt_req = 1'b1;
    mem[v.a] = v.ma;
    mem[v.b] = v.mb;
    if (v.xa != '0) mem[v.xa] = v.xv;
    mem[0] = mk_iw(v.op, v.imm, v.a, v.b);
    if (v.wr) begin e.addr = v.waddr; e.data = v.wdata; exp_q.push_back(e); end
    wait_n = v.waits;
    release_rst();
    wait_halted($sformatf("v%0d", idx), 200);
    chk($sformatf("v%0d_pc", idx), 64'(pc), 64'(v.epc));
    chk($sformatf("v%0d_accesses", idx), 64'(n_acc), 64'(v.nacc));
    chk($sformatf("v%0d_retires", idx), 64'(n_ret), 64'd1);
    chk($sformatf("v%0d_pending_writes", idx), 64'(exp_q.size()), 64'd0);
    chk($sformatf("v%0d_req_parked", idx), 64'(mem_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    wr_t e;
    vt[0]  = mkv(OP_ADD,  1'b0, 14'd1,  14'd2,  32'd5,        32'd7,        14'd0,  32'd0,      0, 1'b1, 14'd1,  32'd12,         14'd1,     4);
    vt[1]  = mkv(OP_NAND, 1'b0, 14'd10, 14'd11, 32'hF0F0F0F0, 32'hFF00FF00, 14'd0,  32'd0,      1, 1'b1, 14'd10, 32'h0FFF0FFF,   14'd1,     4);
    vt[2]  = mkv(OP_SRL,  1'b0, 14'd10, 14'd11, 32'hF0,       32'd4,        14'd0,  32'd0,      0, 1'b1, 14'd10, 32'h0F,         14'd1,     4);
    vt[3]  = mkv(OP_SRL,  1'b0, 14'd10, 14'd11, 32'd1,        32'd64,       14'd0,  32'd0,      2, 1'b1, 14'd10, 32'd0,          14'd1,     4);
    vt[4]  = mkv(OP_SRL,  1'b0, 14'd10, 14'd11, 32'd1,        32'd35,       14'd0,  32'd0,      0, 1'b1, 14'd10, 32'd8,          14'd1,     4);
    vt[5]  = mkv(OP_SRL,  1'b1, 14'd10, 14'd35, 32'd1,        32'd0,        14'd0,  32'd0,      1, 1'b1, 14'd10, 32'd8,          14'd1,     3);
    vt[6]  = mkv(OP_LT,   1'b0, 14'd10, 14'd11, 32'd3,        32'd5,        14'd0,  32'd0,      0, 1'b1, 14'd10, 32'd1,          14'd1,     4);
    vt[7]  = mkv(OP_LT,   1'b1, 14'd10, 14'd5,  32'd9,        32'd0,        14'd0,  32'd0,      0, 1'b1, 14'd10, 32'd0,          14'd1,     3);
    vt[8]  = mkv(OP_MUL,  1'b0, 14'd10, 14'd11, 32'h10000,    32'h10003,    14'd0,  32'd0,      1, 1'b1, 14'd10, 32'h00030000,   14'd1,     4);
    vt[9]  = mkv(OP_ADD,  1'b1, 14'd10, 14'd2,  32'hFFFFFFFF, 32'd0,        14'd0,  32'd0,      0, 1'b1, 14'd10, 32'd1,          14'd1,     3);
    vt[10] = mkv(OP_NAND, 1'b1, 14'd10, 14'h3FFF, 32'hFFFFFFFF, 32'd0,      14'd0,  32'd0,      0, 1'b1, 14'd10, 32'hFFFFC000,   14'd1,     3);
    vt[11] = mkv(OP_MUL,  1'b1, 14'd10, 14'd6,  32'd7,        32'd0,        14'd0,  32'd0,      2, 1'b1, 14'd10, 32'd42,         14'd1,     3);
    vt[12] = mkv(OP_CP,   1'b0, 14'd10, 14'd11, 32'h99,       32'h1234,     14'd0,  32'd0,      0, 1'b1, 14'd10, 32'h1234,       14'd1,     3);
    vt[13] = mkv(OP_CP,   1'b1, 14'd10, 14'h2AAA, 32'h99,     32'd0,        14'd0,  32'd0,      1, 1'b1, 14'd10, 32'h2AAA,       14'd1,     2);
    vt[14] = mkv(OP_CPI,  1'b0, 14'd10, 14'd11, 32'h99,       32'd20,       14'd20, 32'hABCD,   3, 1'b1, 14'd10, 32'hABCD,       14'd1,     4);
    vt[15] = mkv(OP_CPI,  1'b1, 14'd10, 14'd11, 32'd30,       32'h5555,     14'd0,  32'd0,      0, 1'b1, 14'd30, 32'h5555,       14'd1,     4);
    vt[16] = mkv(OP_BZJ,  1'b0, 14'd10, 14'd11, 32'h40,       32'd0,        14'd0,  32'd0,      0, 1'b0, 14'd0,  32'd0,          14'h40,    3);
    vt[17] = mkv(OP_BZJ,  1'b0, 14'd10, 14'd11, 32'h40,       32'd3,        14'd0,  32'd0,      1, 1'b0, 14'd0,  32'd0,          14'd1,     3);
    vt[18] = mkv(OP_BZJ,  1'b1, 14'd10, 14'd5,  32'h100,      32'd0,        14'd0,  32'd0,      0, 1'b0, 14'd0,  32'd0,          14'h105,   2);

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);

    for (int i = 0; i < 19; i++) run_vec(vt[i], i);

    // BZJi to the last address, then a not-taken BZJ there wraps pc to 0.
    start_clean();
    halt_req = 1'b0;
    wait_n = 1;
    mem[0] = mk_iw(OP_BZJ, 1'b1, 14'd100, 14'd0);
    mem[100] = 32'h3FFF;
    mem[14'h3FFF] = mk_iw(OP_BZJ, 1'b0, 14'd101, 14'd102);
    mem[101] = 32'h55;
    mem[102] = 32'd3;
    release_rst();
    k = 0;
    while (!retire && k < 50) begin @(negedge clk); k++; end
    chk("wrap_first_retire", 64'(retire), 64'd1);
    chk("wrap_jump_pc", 64'(pc), 64'h3FFF);
    halt_req = 1'b1;
    wait_halted("wrap", 100);
    chk("wrap_pc", 64'(pc), 64'd0);
    chk("wrap_retires", 64'(n_ret), 64'd2);
    chk("wrap_accesses", 64'(n_acc), 64'd5);

    // halt_req raised during RDB: ADD still writes, then the core parks.
    start_clean();
    halt_req = 1'b0;
    wait_n = 2;
    mem[1] = 32'd5;
    mem[2] = 32'd7;
    mem[0] = mk_iw(OP_ADD, 1'b0, 14'd1, 14'd2);
    e.addr = 14'd1; e.data = 32'd12; exp_q.push_back(e);
    release_rst();
    k = 0;
    while (!(mem_req && mem_addr == 14'd2) && k < 50) begin @(negedge clk); k++; end
    chk("halt_saw_rdb", 64'(mem_addr), 64'd2);
    halt_req = 1'b1;
    wait_halted("halt", 100);
    chk("halt_retires", 64'(n_ret), 64'd1);
    chk("halt_pc", 64'(pc), 64'd1);
    chk("halt_write_done", 64'(exp_q.size()), 64'd0);
    chk("halt_mem1", 64'(mem[1]), 64'd12);
    repeat (3) @(negedge clk);
    #1;
    chk("halt_no_req", 64'(mem_req), 64'd0);
    chk("halt_still_halted", 64'(halted), 64'd1);
    halt_req = 1'b0;
    @(negedge clk); #1;
    chk("resume_req", 64'(mem_req), 64'd1);
    chk("resume_addr", 64'(mem_addr), 64'd1);
    chk("resume_we", 64'(mem_we), 64'd0);
    chk("resume_halted", 64'(halted), 64'd0);
    rst = 1'b1;

    // Reset during a write wait state: request drops immediately and no write lands.
    start_clean();
    halt_req = 1'b0;
    wait_n = 3;
    mem[0] = mk_iw(OP_CP, 1'b1, 14'd10, 14'h77);
    release_rst();
    k = 0;
    while (!(mem_req && mem_we) && k < 50) begin @(negedge clk); k++; end
    chk("rstw_saw_write", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstw_req", 64'(mem_req), 64'd0);
    chk("rstw_we", 64'(mem_we), 64'd0);
    chk("rstw_addr", 64'(mem_addr), 64'd0);
    chk("rstw_wdata", 64'(mem_wdata), 64'd0);
    chk("rstw_pc", 64'(pc), 64'd0);
    repeat (2) @(negedge clk);
    chk("rstw_no_write", 64'(mem[10]), 64'd0);
    release_rst();
    @(negedge clk); #1;
    chk("rstw_refetch_req", 64'(mem_req), 64'd1);
    chk("rstw_refetch_addr", 64'(mem_addr), 64'd0);
    chk("rstw_refetch_we", 64'(mem_we), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
